// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states, frame layout
// constants, keyboard scan-code markers and the parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    localparam logic [7:0] BREAK = 8'hF0;
    localparam logic [7:0] EXT   = 8'hE0;

    // PS/2 frames carry odd parity: the data byte plus its parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] byte_val, input logic par);
        return ^{byte_val, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx_sync_fifo.sv
// First-word-fall-through byte FIFO; pointers carry one extra wrap bit so
// all DEPTH entries are usable.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises the raw lines, checks
// start/parity/stop, abandons stalled frames and buffers good bytes in a FIFO.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       sampling,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          fall;
    logic          rx_bit;

    rx_state_t     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          push;
    logic          perr_d;
    logic          ferr_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_ok;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Edge seen between stages 2 and 3; the 2-flop data chain lines up with it.
    assign fall   = !clk_sync[1] && clk_sync[2];
    assign rx_bit = data_sync[1];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            parity_q   <= 1'b0;
            tmo_cnt_q  <= '0;
            sampling   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            parity_q   <= parity_d;
            tmo_cnt_q  <= tmo_cnt_d;
            sampling   <= fall;
            parity_err <= perr_d;
            frame_err  <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        tmo_cnt_d = '0;
        push      = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        if (state_q != IDLE) tmo_cnt_d = tmo_cnt_q + TW'(1);

        if (fall) begin
            tmo_cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (rx_bit == START_BIT) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d[bit_cnt_q] = rx_bit;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = rx_bit;
                    state_d  = STOP;
                end
                STOP: begin
                    // A bad stop bit outranks a parity error when both occur.
                    state_d = IDLE;
                    if (rx_bit != STOP_BIT)                   ferr_d = 1'b1;
                    else if (!odd_parity_ok(shift_q, parity_q)) perr_d = 1'b1;
                    else                                      push   = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
        end
    end

    assign ready  = !fifo_empty;
    assign pop_ok = !nextdata_n && ready;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            overflow <= 1'b0;
        end else if (pop_ok) begin
            overflow <= 1'b0;
        end else if (push && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push),
        .din   (shift_q),
        .pop   (pop_ok),
        .dout  (data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: bit-bangs PS/2 frames and checks the FIFO
// interface and error pulses against hand-computed values.
module tb_ps2_frame_rx;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       sampling;
    logic       parity_err;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int samp_cnt = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;

    always #5 clk = ~clk;

    ps2_frame_rx #(
        .DEPTH       (8),
        .TIMEOUT_CYC (200)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .sampling   (sampling),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always @(negedge clk) begin
        if (sampling)   samp_cnt++;
        if (parity_err) perr_cnt++;
        if (frame_err)  ferr_cnt++;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // The stop-edge pop lands nextdata_n low in exactly the cycle the edge is detected.
    task automatic apply_stimulus(input logic [7:0] b, input logic par, input logic stp, input bit pop_on_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        if (pop_on_stop) begin
            ps2_data = stp;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b0;
            @(negedge clk);
            @(negedge clk);
            nextdata_n = 1'b0;
            @(negedge clk);
            nextdata_n = 1'b1;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end else begin
            send_bit(stp);
        end
        ps2_data = 1'b1;
    endtask

    task automatic pop_one();
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    initial begin
        int p0, f0, s0, cnt, tcnt;
        logic [7:0] exp_q [8];

        clrn       = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("rst_ready",    32'(ready),      32'h0);
        check_output("rst_data",     32'(data),       32'h0);
        check_output("rst_overflow", 32'(overflow),   32'h0);
        check_output("rst_sampling", 32'(sampling),   32'h0);
        check_output("rst_perr",     32'(parity_err), 32'h0);
        check_output("rst_ferr",     32'(frame_err),  32'h0);
        clrn = 1'b1;
        @(negedge clk);

        $display("[TB] good byte 0x1C");
        p0 = perr_cnt; f0 = ferr_cnt;
        apply_stimulus(8'h1C, 1'b0, 1'b1, 1'b0);
        check_output("good_ready", 32'(ready), 32'h1);
        check_output("good_data",  32'(data),  32'h1C);
        pop_one();
        check_output("good_pop_ready", 32'(ready), 32'h0);
        check_output("good_pop_data",  32'(data),  32'h0);
        check_output("good_no_perr", 32'(perr_cnt - p0), 32'h0);
        check_output("good_no_ferr", 32'(ferr_cnt - f0), 32'h0);

        $display("[TB] sequence 0xF0, 0x1C");
        s0 = samp_cnt;
        apply_stimulus(8'hF0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(8'h1C, 1'b0, 1'b1, 1'b0);
        check_output("seq_sampling_cnt", 32'(samp_cnt - s0), 32'd22);
        check_output("seq_ready", 32'(ready), 32'h1);
        check_output("seq_head0", 32'(data),  32'hF0);
        pop_one();
        check_output("seq_head1", 32'(data),  32'h1C);
        pop_one();
        check_output("seq_empty", 32'(ready), 32'h0);

        $display("[TB] overflow");
        for (int k = 1; k <= 9; k++) apply_stimulus(8'(k), odd_par(8'(k)), 1'b1, 1'b0);
        check_output("ovf_set",  32'(overflow), 32'h1);
        check_output("ovf_head", 32'(data),     32'h01);
        pop_one();
        check_output("ovf_clear",     32'(overflow), 32'h0);
        check_output("ovf_head_next", 32'(data),     32'h02);
        apply_stimulus(8'h0A, odd_par(8'h0A), 1'b1, 1'b0);
        check_output("refill_no_ovf", 32'(overflow), 32'h0);

        $display("[TB] push into full FIFO with simultaneous pop");
        apply_stimulus(8'h0B, odd_par(8'h0B), 1'b1, 1'b1);
        check_output("fullpop_no_ovf", 32'(overflow), 32'h0);
        exp_q = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h0B};
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("drain_ready_%0d", i), 32'(ready), 32'h1);
            check_output($sformatf("drain_data_%0d", i),  32'(data),  32'(exp_q[i]));
            nextdata_n = 1'b0;
            @(negedge clk);
        end
        nextdata_n = 1'b1;
        check_output("drain_empty_ready", 32'(ready), 32'h0);
        check_output("drain_empty_data",  32'(data),  32'h0);

        $display("[TB] error frames");
        p0 = perr_cnt; f0 = ferr_cnt;
        apply_stimulus(8'h1C, 1'b1, 1'b1, 1'b0);
        check_output("bad_par_perr",  32'(perr_cnt - p0), 32'h1);
        check_output("bad_par_ferr",  32'(ferr_cnt - f0), 32'h0);
        check_output("bad_par_ready", 32'(ready), 32'h0);
        p0 = perr_cnt; f0 = ferr_cnt;
        apply_stimulus(8'h1C, 1'b0, 1'b0, 1'b0);
        check_output("bad_stop_ferr",  32'(ferr_cnt - f0), 32'h1);
        check_output("bad_stop_perr",  32'(perr_cnt - p0), 32'h0);
        check_output("bad_stop_ready", 32'(ready), 32'h0);
        p0 = perr_cnt; f0 = ferr_cnt;
        apply_stimulus(8'h1C, 1'b1, 1'b0, 1'b0);
        check_output("both_bad_ferr", 32'(ferr_cnt - f0), 32'h1);
        check_output("both_bad_perr", 32'(perr_cnt - p0), 32'h0);
        f0 = ferr_cnt;
        send_bit(1'b1);
        check_output("glitch_ferr",  32'(ferr_cnt - f0), 32'h1);
        check_output("glitch_ready", 32'(ready), 32'h0);
        apply_stimulus(8'h1C, 1'b0, 1'b1, 1'b0);
        check_output("after_glitch_data", 32'(data), 32'h1C);
        pop_one();

        $display("[TB] timeout");
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        cnt = 0;
        while (!sampling && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check_output("tmo_last_edge_seen", 32'(sampling), 32'h1);
        tcnt = 0;
        while (!frame_err && tcnt < 400) begin
            @(negedge clk);
            tcnt++;
            if (tcnt == 5) ps2_clk = 1'b1;
        end
        check_output("tmo_cycles", 32'(tcnt), 32'd200);
        check_output("tmo_ready",  32'(ready), 32'h0);
        apply_stimulus(8'h1C, 1'b0, 1'b1, 1'b0);
        check_output("after_tmo_ready", 32'(ready), 32'h1);
        check_output("after_tmo_data",  32'(data),  32'h1C);

        $display("[TB] reset mid-frame");
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        clrn = 1'b0;
        #1;
        check_output("midrst_ready",    32'(ready),      32'h0);
        check_output("midrst_data",     32'(data),       32'h0);
        check_output("midrst_overflow", 32'(overflow),   32'h0);
        check_output("midrst_sampling", 32'(sampling),   32'h0);
        check_output("midrst_perr",     32'(parity_err), 32'h0);
        check_output("midrst_ferr",     32'(frame_err),  32'h0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        apply_stimulus(8'h5A, 1'b1, 1'b1, 1'b0);
        check_output("post_rst_ready", 32'(ready), 32'h1);
        check_output("post_rst_data",  32'(data),  32'h5A);
        pop_one();
        check_output("post_rst_empty", 32'(ready), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
